// File: rtl/ahb_arbiter.sv
// Fixed-priority AHB bus arbiter. A fixed-length burst freezes the grant until
// its last beat. Locked transfers keep the grant with the current owner.
module ahb_arbiter #(
  parameter int MASTER_NUMBER = 4
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic [MASTER_NUMBER-1:0] hbusreq,
  input  logic [MASTER_NUMBER-1:0] hlock,
  input  logic                     hready,
  input  logic [1:0]               htrans,
  input  logic [2:0]               hburst,
  output logic [MASTER_NUMBER-1:0] hgrant,
  output logic [3:0]               hmaster,
  output logic                     hmastlock
);
  localparam int                     MN        = MASTER_NUMBER;
  localparam logic [3:0]             DEF       = 4'(MN-1);
  localparam logic [MN-1:0]          RST_GRANT = {1'b1, {(MN-1){1'b0}}};
  localparam logic [1:0]             BUSY      = 2'd1;
  localparam logic [1:0]             NONSEQ    = 2'd2;
  localparam logic [1:0]             SEQ       = 2'd3;

  typedef enum logic {ARB, BURST} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [3:0]    cur;
  logic [MN-1:0] win;
  logic          cur_locked;
  logic [3:0]    blen;
  logic          fixed_burst;

  // Binary index of the current one-hot grant.
  always_comb begin
    cur = '0;
    for (int i = 0; i < MN; i++)
      if (hgrant[i]) cur = cur | 4'(i);
  end

  // hgrant is one-hot, so masking selects exactly the grantee's request/lock.
  assign cur_locked = |(hgrant & hbusreq & hlock);

  // Lowest index requester wins unless the grantee holds a locked request.
  always_comb begin
    win = RST_GRANT;
    for (int i = MN-1; i >= 0; i--)
      if (hbusreq[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    if (cur_locked) win = hgrant;
  end

  assign fixed_burst = |hburst[2:1];

  always_comb begin
    case (hburst)
      3'd2, 3'd3: blen = 4'd3;
      3'd4, 3'd5: blen = 4'd7;
      3'd6, 3'd7: blen = 4'd15;
      default:    blen = 4'd0;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= ARB;
      cnt       <= '0;
      hgrant    <= RST_GRANT;
      hmaster   <= DEF;
      hmastlock <= 1'b0;
    end else if (hready) begin
      hmaster   <= cur;
      hmastlock <= cur_locked;
      case (state)
        ARB:
          if (htrans == NONSEQ && fixed_burst) begin
            state <= BURST;
            cnt   <= blen;
          end else begin
            hgrant <= win;
          end
        BURST:
          case (htrans)
            SEQ: begin
              cnt <= cnt - 4'd1;
              // Handover on the last beat so the next owner overlaps it.
              if (cnt == 4'd1) begin
                state  <= ARB;
                hgrant <= win;
              end
            end
            BUSY: ;
            default: begin
              state  <= ARB;
              cnt    <= '0;
              hgrant <= win;
            end
          endcase
        default: state <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed literal scenarios plus randomized traffic
// compared every cycle against a transaction-level ownership model.
module tb_ahb_arbiter;
  localparam int N = 4;

  logic         hclk = 1'b0;
  logic         hreset;
  logic [N-1:0] hbusreq, hlock;
  logic         hready;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic [N-1:0] hgrant;
  logic [3:0]   hmaster;
  logic         hmastlock;

  int checks = 0;
  int errors = 0;

  ahb_arbiter #(.MASTER_NUMBER(N)) dut (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
    .hready(hready), .htrans(htrans), .hburst(hburst),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_grant, m_master, m_left;
  bit m_lock, m_inburst;

  function automatic int beats_of(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  function automatic int pick(input int owner, input logic [N-1:0] req, input logic [N-1:0] lck);
    if (req[owner] && lck[owner]) return owner;
    for (int i = 0; i < N; i++) if (req[i]) return i;
    return N-1;
  endfunction

  always @(posedge hclk or posedge hreset) begin
    int w, nleft;
    if (hreset) begin
      m_grant <= N-1; m_master <= N-1; m_lock <= 1'b0;
      m_inburst <= 1'b0; m_left <= 0;
    end else if (hready) begin
      w = pick(m_grant, hbusreq, hlock);
      m_master <= m_grant;
      m_lock   <= hbusreq[m_grant] && hlock[m_grant];
      if (!m_inburst) begin
        if (htrans == 2'd2 && beats_of(hburst) > 1) begin
          m_inburst <= 1'b1;
          m_left    <= beats_of(hburst) - 1;
        end else m_grant <= w;
      end else if (htrans == 2'd3) begin
        nleft = m_left - 1;
        m_left <= nleft;
        if (nleft == 0) begin m_inburst <= 1'b0; m_grant <= w; end
      end else if (htrans != 2'd1) begin
        m_inburst <= 1'b0; m_left <= 0; m_grant <= w;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [3:0] prev_master;
  logic       prev_lock, prev_ready, prev_rst;
  bit         armed = 1'b0;

  always @(negedge hclk) begin
    if (armed) begin
      chk("grant_model", hgrant, 32'(1) << m_grant);
      chk("master_model", hmaster, 32'(m_master));
      chk("mastlock_model", hmastlock, 32'(m_lock));
      chk("grant_onehot", 32'($onehot(hgrant)), 32'd1);
      if (!prev_ready && !prev_rst && !hreset) begin
        chk("master_hold", hmaster, prev_master);
        chk("mastlock_hold", hmastlock, prev_lock);
      end
    end
    prev_master = hmaster; prev_lock = hmastlock;
    prev_ready = hready;   prev_rst = hreset;
  end

  task automatic tick();
    @(posedge hclk);
    #2;
  endtask

  task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy,
                        input logic [1:0] t, input logic [2:0] b);
    hbusreq = r; hlock = l; hready = rdy; htrans = t; hburst = b;
  endtask

  initial begin
    bit done;
    hreset = 1'b1;
    set_in('0, '0, 1'b1, 2'd0, 3'd0);
    #1;
    chk("reset_grant", hgrant, 32'b1000);
    chk("reset_master", hmaster, 32'd3);
    chk("reset_mastlock", hmastlock, 32'd0);
    tick(); tick();
    hreset = 1'b0;
    armed  = 1'b1;

    // Priority: lowest index requester wins; ownership one edge later.
    set_in(4'b0110, '0, 1'b1, 2'd0, 3'd0);
    tick(); chk("prio_grant", hgrant, 32'b0010);
    tick(); chk("prio_master", hmaster, 32'd1);

    // INCR4 by master 2 with master 0 requesting from beat 1, one wait and one BUSY.
    set_in(4'b0100, '0, 1'b1, 2'd0, 3'd0);
    tick(); tick(); chk("burst_owner", hmaster, 32'd2);
    set_in(4'b0101, '0, 1'b1, 2'd2, 3'd3);
    tick(); chk("burst_b1", hgrant, 32'b0100);
    htrans = 2'd3;
    tick(); chk("burst_b2", hgrant, 32'b0100);
    hready = 1'b0;
    tick(); chk("burst_wait", hgrant, 32'b0100);
    hready = 1'b1; htrans = 2'd1;
    tick(); chk("burst_busy", hgrant, 32'b0100);
    htrans = 2'd3;
    tick(); chk("burst_b3", hgrant, 32'b0100);
    tick(); chk("burst_b4", hgrant, 32'b0001);
    htrans = 2'd0;

    // Locked grantee beats a higher-priority request.
    set_in(4'b1000, 4'b1000, 1'b1, 2'd0, 3'd0);
    tick(); chk("lock_grant", hgrant, 32'b1000);
    hbusreq = 4'b1001;
    tick(); chk("lock_hold", hgrant, 32'b1000);
    chk("lock_mastlock", hmastlock, 32'd1);
    tick(); chk("lock_hold2", hgrant, 32'b1000);
    hlock = '0;
    tick(); chk("lock_release", hgrant, 32'b0001);

    // All requests drop: default master within 3 cycles.
    hbusreq = '0;
    done = 1'b0;
    for (int i = 0; i < 3 && !done; i++) begin
      tick();
      if (hgrant == 4'b1000) done = 1'b1;
    end
    chk("default_within_3", 32'(done), 32'd1);

    // Reset mid-INCR8, then fresh arbitration.
    set_in(4'b0010, '0, 1'b1, 2'd0, 3'd0);
    tick(); tick();
    htrans = 2'd2; hburst = 3'd5;
    tick(); htrans = 2'd3;
    tick(); tick();
    chk("incr8_grant", hgrant, 32'b0010);
    hreset = 1'b1;
    #1;
    chk("midburst_rst_grant", hgrant, 32'b1000);
    chk("midburst_rst_master", hmaster, 32'd3);
    chk("midburst_rst_lock", hmastlock, 32'd0);
    tick();
    hreset = 1'b0;
    set_in(4'b0110, '0, 1'b1, 2'd3, 3'd0);
    tick(); chk("post_rst_grant", hgrant, 32'b0010);
    htrans = 2'd0;
    tick(); chk("post_rst_master", hmaster, 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      r = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      hbusreq = r;
      hlock   = r & N'($urandom);
      hready  = ($urandom_range(0, 3) != 0);
      if (m_inburst && $urandom_range(0, 9) < 7) htrans = 2'd3;
      else htrans = 2'($urandom_range(0, 3));
      hburst  = 3'($urandom_range(0, 7));
      hreset  = ($urandom_range(0, 199) == 0);
      tick();
    end
    hreset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
- REQ-001: Parameter MASTER_NUMBER SHALL be: default 4, legal range 2..16, number of bus masters.
- REQ-002: Port hclk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
- REQ-003: Port hreset SHALL be: input, 1 bit, asynchronous, active-high reset.
- REQ-004: Port hbusreq SHALL be: input, MASTER_NUMBER bits, bus request, bit i from master i.
- REQ-005: Port hlock SHALL be: input, MASTER_NUMBER bits, locked-access request, bit i from master i.
- REQ-006: Port hready SHALL be: input, 1 bit, transfer-complete from the slave side.
- REQ-007: Port htrans SHALL be: input, 2 bits, transfer type of the current owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- REQ-008: Port hburst SHALL be: input, 3 bits, burst type of the current owner (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
- REQ-009: Port hgrant SHALL be: output, MASTER_NUMBER bits, one-hot grant.
- REQ-010: Port hmaster SHALL be: output, 4 bits, index of the master owning the address phase.
- REQ-011: Port hmastlock SHALL be: output, 1 bit, current address-phase transfer is locked.

Function
- REQ-012: Priority SHALL be fixed: master 0 highest, master MASTER_NUMBER-1 lowest and default master.
- REQ-013: Arbitration result SHALL be: the current grantee if its hbusreq and hlock bits are both 1; else the lowest-index master with hbusreq=1; else the default master.
- REQ-014: hgrant SHALL always be exactly one-hot, registered, never combinational from inputs.
- REQ-015: FSM states SHALL be ARB (grant may move) and BURST (grant frozen during a fixed-length burst).
- REQ-016: In ARB, on a rising edge with hready=1, hgrant SHALL load the arbitration result; with hready=0, hgrant SHALL hold.
- REQ-017: In ARB, on hready=1 with htrans=NONSEQ and hburst in {WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16}, the FSM SHALL go to BURST, load a 4-bit beat counter with length-1 (3, 7 or 15), and hold hgrant.
- REQ-018: SINGLE and INCR bursts SHALL NOT enter BURST; they are re-arbitrated every hready=1 cycle.
- REQ-019: In BURST, on hready=1 with htrans=SEQ, the counter SHALL decrement.
- REQ-020: On that same edge, if the counter equals 1, the FSM SHALL return to ARB and hgrant SHALL load the arbitration result, so the handover overlaps the last beat.
- REQ-021: In BURST, htrans=BUSY or hready=0 SHALL hold the counter, the state and hgrant.
- REQ-022: In BURST, hready=1 with htrans=IDLE or NONSEQ (early termination) SHALL return to ARB and load the arbitration result on that edge.
- REQ-023: On every rising edge with hready=1, hmaster SHALL load the binary index of the hgrant value present before that edge; hmaster SHALL hold when hready=0.
- REQ-024: On those same edges, hmastlock SHALL load hlock[that index] AND hbusreq[that index].
- REQ-025: Grant-to-ownership latency SHALL be exactly one hready=1 edge after hgrant changes.
- REQ-026: Once all hbusreq drop to 0, with hready=1 and state ARB, hgrant SHALL equal the default master within 1 cycle, and within 3 cycles in all non-BURST cases.
- REQ-027: Simultaneous requests SHALL resolve by REQ-013 only; a lock held by a lower-priority grantee SHALL beat a new higher-priority request.

Reset
- REQ-028: While hreset=1, outputs SHALL be forced immediately, independent of hclk, to: hgrant = 1<<(MASTER_NUMBER-1), hmaster = MASTER_NUMBER-1, hmastlock=0; state=ARB and counter=0.
- REQ-029: Reset asserted mid-burst SHALL abandon the burst, with no residual counter state after release.
- REQ-030: The first arbitration after release SHALL occur on the first rising edge with hreset=0 and hready=1.

Verification
- REQ-031: Reset check: hreset=1 with MASTER_NUMBER=4 -> hgrant=4'b1000, hmaster=3, hmastlock=0, checked before any clock edge.
- REQ-032: Priority check: hbusreq=4'b0110, hready=1 -> next edge hgrant=4'b0010; following edge hmaster=1.
- REQ-033: Burst check: master 2 owns the bus and issues NONSEQ INCR4 then 3 SEQ beats with hready=1, while master 0 requests from beat 1 -> hgrant stays 4'b0100 until the edge accepting beat 4, then 4'b0001; beats with hready=0 or BUSY inserted mid-burst extend the hold by the same number of cycles.
- REQ-034: Lock check: master 3 is granted with hbusreq[3]=1 and hlock[3]=1, and master 0 requests -> hgrant stays 4'b1000 and hmastlock=1; after hlock[3] drops, hgrant=4'b0001 on the next hready=1 edge.
- REQ-035: Default and reset checks: all hbusreq=0 from any state -> hgrant=4'b1000 within 3 cycles; hreset pulsed mid-INCR8 -> immediate reset values; a fresh request after release is granted per REQ-032.
- REQ-036: Continuous assertions SHALL check that hgrant is always one-hot and that hmaster/hmastlock never change on a cycle with hready=0.
